// File: rtl/arbiter_rr.sv
// arbiter_rr: round-robin arbiter with registered one-hot grant and optional per-port grant timeout.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset
//   req      - per-port request, bit i = port i
//   flit_id  - per-port flit id, port i in [i*FID_W +: FID_W]
//   length   - per-port packet length, port i in [i*LEN_W +: LEN_W]
//   grant    - registered one-hot grant, zero when idle
//   grant_id - index of granted port, zero when idle
//   busy     - high while a grant is held
//   timeout  - one-cycle pulse on bit i in the last allowed cycle of a timed-out grant
// Build option: define ARB_TIMEOUT_EN to build the per-port count/limit registers and timeout logic.
module arbiter_rr #(
   parameter int NPORTS    = 5,
   parameter int LEN_W     = 12,
   parameter int FID_W     = 3,
   parameter int HEADER_ID = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NPORTS-1:0]         req,
   input  logic [NPORTS*FID_W-1:0]   flit_id,
   input  logic [NPORTS*LEN_W-1:0]   length,
   output logic [NPORTS-1:0]         grant,
   output logic [$clog2(NPORTS)-1:0] grant_id,
   output logic                      busy,
   output logic [NPORTS-1:0]         timeout
);
   localparam int IDW = $clog2(NPORTS);
   localparam logic [IDW:0] NP = (IDW+1)'(NPORTS);
   localparam logic [NPORTS-1:0] ONE = NPORTS'(1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t              state_q, state_d;
   logic [NPORTS-1:0]   grant_q, grant_d;
   logic [IDW-1:0]      gid_q, gid_d;
   logic [IDW-1:0]      ptr_q, ptr_d;
   logic [NPORTS-1:0]   to;
   logic [NPORTS-1:0]   cand;
   logic [2*NPORTS-1:0] dbl;
   logic [IDW:0]        pos;
   logic [IDW-1:0]      sel;
   logic                hold;

`ifdef ARB_TIMEOUT_EN
   logic [LEN_W-1:0] cnt_q [NPORTS];
   logic [LEN_W-1:0] lim_q [NPORTS];

   // Count holds cycles already spent in the grant, so cycle n of the grant sees count n-1.
   always_comb begin
      to = '0;
      for (int i = 0; i < NPORTS; i++)
         to[i] = grant_q[i] && req[i] && (lim_q[i] != '0) &&
                 (({1'b0, cnt_q[i]} + (LEN_W+1)'(1)) >= {1'b0, lim_q[i]});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NPORTS; i++) begin
            cnt_q[i] <= '0;
            lim_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NPORTS; i++) begin
            cnt_q[i] <= (grant_q[i] && req[i] && !to[i]) ? cnt_q[i] + LEN_W'(1) : '0;
            if (flit_id[i*FID_W +: FID_W] == FID_W'(HEADER_ID))
               lim_q[i] <= length[i*LEN_W +: LEN_W];
         end
      end
   end
`else
   logic unused_inputs;
   assign unused_inputs = ^{flit_id, length};
   assign to = '0;
`endif

   // Search runs over a doubled request vector so ptr+k never needs a modulo;
   // iterating from the far end lets the nearest requester after ptr win.
   // The current holder is masked so a dropped or timed-out port is skipped.
   always_comb begin
      cand = req & ~grant_q;
      dbl  = {cand, cand};
      sel  = '0;
      pos  = '0;
      for (int k = NPORTS; k >= 1; k--) begin
         pos = {1'b0, ptr_q} + k[IDW:0];
         if (dbl[pos]) sel = (pos >= NP) ? IDW'(pos - NP) : pos[IDW-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      hold    = (state_q == GRANT) && req[gid_q] && !(|to);
      if (!hold) begin
         state_d = IDLE;
         grant_d = '0;
         gid_d   = '0;
         if (|cand) begin
            state_d = GRANT;
            grant_d = ONE << sel;
            gid_d   = sel;
            ptr_d   = sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         gid_q   <= '0;
         ptr_q   <= IDW'(NPORTS-1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant    = grant_q;
   assign grant_id = gid_q;
   assign busy     = (state_q == GRANT);
   assign timeout  = to;
endmodule

// File: tb/tb_arbiter_rr.sv
// tb_arbiter_rr: directed self-checking bench for arbiter_rr (default parameters).
module tb_arbiter_rr;
   localparam int N  = 5;
   localparam int LW = 12;
   localparam int FW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N*FW-1:0] flit_id = '0;
   logic [N*LW-1:0] length = '0;
   logic [N-1:0]    grant;
   logic [2:0]      grant_id;
   logic            busy;
   logic [N-1:0]    timeout;
   int checks = 0;
   int errors = 0;

   arbiter_rr #(.NPORTS(N), .LEN_W(LW), .FID_W(FW), .HEADER_ID(1)) dut (
      .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
      .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2 rst = 1'b0;
      step(2);
      checks++;
      if ({grant, grant_id, busy, timeout} !== '0) begin
         errors++;
         $display("FAIL reset_state: grant=%b id=%0d busy=%b timeout=%b, want all zero", grant, grant_id, busy, timeout);
      end
      rst = 1'b1;
      req = 5'b00110;
      step();
      checks++;
      if ({grant, grant_id, busy} !== {5'b00010, 3'd1, 1'b1}) begin
         errors++;
         $display("FAIL reset_release: grant=%b id=%0d busy=%b, want 00010/1/1", grant, grant_id, busy);
      end
   endtask

   task automatic test_rotation;
      logic [N-1:0] rq [4] = '{5'b10110, 5'b10100, 5'b10000, 5'b00000};
      logic [N-1:0] eg [4] = '{5'b00010, 5'b00100, 5'b10000, 5'b00000};
      logic [2:0]   ei [4] = '{3'd1, 3'd2, 3'd4, 3'd0};
      for (int s = 0; s < 4; s++) begin
         req = rq[s];
         step();
         checks++;
         if ({grant, grant_id, busy} !== {eg[s], ei[s], eg[s] != '0}) begin
            errors++;
            $display("FAIL rotation step %0d: grant=%b id=%0d busy=%b, want %b/%0d", s, grant, grant_id, busy, eg[s], ei[s]);
         end
      end
   endtask

   task automatic test_search_order;
      logic [N-1:0] rq [4] = '{5'b01010, 5'b00000, 5'b10001, 5'b00000};
      logic [N-1:0] eg [4] = '{5'b00010, 5'b00000, 5'b10000, 5'b00000};
      logic [2:0]   ei [4] = '{3'd1, 3'd0, 3'd4, 3'd0};
      for (int s = 0; s < 4; s++) begin
         req = rq[s];
         step();
         checks++;
         if ({grant, grant_id} !== {eg[s], ei[s]}) begin
            errors++;
            $display("FAIL search_order step %0d: grant=%b id=%0d, want %b/%0d", s, grant, grant_id, eg[s], ei[s]);
         end
      end
   endtask

   task automatic test_timeout;
      logic [5:0] eg;
      logic [5:0] et;
`ifdef ARB_TIMEOUT_EN
      eg = 6'b101111;
      et = 6'b001000;
`else
      eg = 6'b111111;
      et = 6'b000000;
`endif
      flit_id[3*FW +: FW] = 3'd1;
      length[3*LW +: LW]  = 12'd4;
      step();
      flit_id = '0;
      req = 5'b01000;
      for (int c = 0; c < 6; c++) begin
         step();
         checks++;
         if ({grant, timeout} !== {(eg[c] ? 5'b01000 : 5'b00000), (et[c] ? 5'b01000 : 5'b00000)}) begin
            errors++;
            $display("FAIL timeout cycle %0d: grant=%b timeout=%b, want grant bit3=%b timeout bit3=%b", c+1, grant, timeout, eg[c], et[c]);
         end
      end
      req = '0;
      step();
   endtask

   task automatic test_drop_at_limit;
      req = 5'b01000;
      step(4);
      req = '0;
      #1;
      checks++;
      if ({grant, timeout} !== {5'b01000, 5'b00000}) begin
         errors++;
         $display("FAIL drop_at_limit: grant=%b timeout=%b, want 01000/00000", grant, timeout);
      end
      step();
      checks++;
      if (grant !== 5'b00000) begin
         errors++;
         $display("FAIL drop_at_limit_idle: grant=%b, want 00000", grant);
      end
   endtask

   task automatic test_no_timeout;
      flit_id[0 +: FW] = 3'd1;
      length[0 +: LW]  = 12'd0;
      step();
      flit_id = '0;
      req = 5'b00101;
      step();
      for (int c = 0; c < 100; c++) begin
         checks++;
         if ({grant, timeout} !== {5'b00001, 5'b00000}) begin
            errors++;
            $display("FAIL no_timeout cycle %0d: grant=%b timeout=%b, want 00001/00000", c+1, grant, timeout);
         end
         step();
      end
      req = '0;
      step();
   endtask

   task automatic test_async_reset;
      req = 5'b00100;
      step();
      checks++;
      if (grant !== 5'b00100) begin
         errors++;
         $display("FAIL pre_reset_grant: grant=%b, want 00100", grant);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({grant, grant_id, busy} !== '0) begin
         errors++;
         $display("FAIL async_reset: grant=%b id=%0d busy=%b, want zero", grant, grant_id, busy);
      end
      step(2);
      checks++;
      if (grant !== 5'b00000) begin
         errors++;
         $display("FAIL reset_held: grant=%b, want 00000", grant);
      end
      rst = 1'b1;
      req = 5'b11111;
      step();
      checks++;
      if ({grant, grant_id} !== {5'b00001, 3'd0}) begin
         errors++;
         $display("FAIL post_reset_grant: grant=%b id=%0d, want 00001/0", grant, grant_id);
      end
      req = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_search_order();
      test_timeout();
      test_drop_at_limit();
      test_no_timeout();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
